// File: rtl/cpu_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : cpu_pkg
//  Description : Shared opcode and fetch-state types for the CPU front end.
//  Revision    : 1.0 - initial release
// =============================================================================
package cpu_pkg;

    typedef logic [3:0] opcode_t;

    // The opcode field is top-aligned: instr[IW-1 -: OPCODE_W].
    localparam int      OPCODE_W = 4;
    localparam opcode_t OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_halt(input opcode_t op);
        return op == OP_HALT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_imem.sv
`default_nettype none
// =============================================================================
//  Module      : imem
//  Description : DEPTH x IW instruction memory, synchronous write, async read.
//  Revision    : 1.0 - initial release
// =============================================================================
module imem #(
    parameter  int DEPTH = 16,
    parameter  int IW    = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);

    // Contents are deliberately not reset so a loaded program survives rst.
    logic [IW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
//  Module      : fetch_unit
//  Description : PC, IDLE/RUN/HALT sequencer and IF/ID register feeding decode.
//  Revision    : 1.0 - initial release
// =============================================================================
module fetch_unit
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 16,
    parameter  int IW    = 16,
    localparam int PC_W  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            imem_we,
    input  logic [PC_W-1:0] imem_addr,
    input  logic [IW-1:0]   imem_wdata,
    output logic [IW-1:0]   instr,
    output logic [3:0]      opcode,
    output logic [PC_W-1:0] pc_out,
    output logic            valid,
    output logic            halted
);

    fetch_state_t    r_state;
    logic [PC_W-1:0] r_pc;
    logic [IW-1:0]   r_instr;
    logic [PC_W-1:0] r_pc_out;
    logic            r_valid;

    logic [IW-1:0]   w_word;
    logic            w_we;
    opcode_t         w_fetch_op;

    // Program loading is only allowed while the fetch stream is stopped.
    assign w_we       = imem_we && (r_state != RUN);
    assign w_fetch_op = w_word[IW-1 -: OPCODE_W];

    imem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (imem_addr),
        .i_wdata (imem_wdata),
        .i_raddr (r_pc),
        .o_rdata (w_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= '0;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    r_valid <= 1'b0;
                    if (start) begin
                        r_state <= RUN;
                        r_pc    <= '0;
                    end
                end
                RUN: begin
                    // A branch flushes even a halt word: that word is wrong-path.
                    if (branch_taken) begin
                        r_pc    <= branch_target;
                        r_valid <= 1'b0;
                    end else if (stall) begin
                        r_pc    <= r_pc;
                    end else if (is_halt(w_fetch_op)) begin
                        r_valid <= 1'b0;
                        r_state <= HALT;
                    end else begin
                        r_instr  <= w_word;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_pc     <= r_pc + PC_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign instr  = r_instr;
    assign opcode = r_instr[IW-1 -: OPCODE_W];
    assign pc_out = r_pc_out;
    assign valid  = r_valid;
    assign halted = (r_state == HALT);

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed plus randomized bench for fetch_unit with a ref model.
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;

    localparam int DEPTH = 16;
    localparam int IW    = 16;
    localparam int PC_W  = 4;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_HALT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic            stall;
    logic            branch_taken;
    logic [PC_W-1:0] branch_target;
    logic            imem_we;
    logic [PC_W-1:0] imem_addr;
    logic [IW-1:0]   imem_wdata;
    logic [IW-1:0]   instr;
    logic [3:0]      opcode;
    logic [PC_W-1:0] pc_out;
    logic            valid;
    logic            halted;

    int n_total = 0;
    int n_pass  = 0;

    int unsigned m_mem [DEPTH];
    int          m_state;
    int unsigned m_pc;
    int unsigned m_instr;
    int unsigned m_pc_out;
    int unsigned m_valid;

    fetch_unit #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_we       (imem_we),
        .imem_addr     (imem_addr),
        .imem_wdata    (imem_wdata),
        .instr         (instr),
        .opcode        (opcode),
        .pc_out        (pc_out),
        .valid         (valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference behaviour for one rising edge, written from the fetch rules.
    task automatic model_edge();
        int unsigned word;
        if (rst) begin
            m_state  = S_IDLE;
            m_pc     = 0;
            m_instr  = 0;
            m_pc_out = 0;
            m_valid  = 0;
        end else if (m_state != S_RUN) begin
            if (imem_we) m_mem[imem_addr] = imem_wdata;
            if (start) begin
                m_state = S_RUN;
                m_pc    = 0;
            end
            m_valid = 0;
        end else begin
            word = m_mem[m_pc];
            if (branch_taken) begin
                m_pc    = branch_target;
                m_valid = 0;
            end else if (stall) begin
                m_valid = m_valid;
            end else if ((word >> 12) == 15) begin
                m_valid = 0;
                m_state = S_HALT;
            end else begin
                m_instr  = word;
                m_pc_out = m_pc;
                m_valid  = 1;
                m_pc     = (m_pc + 1) % DEPTH;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("instr",  instr,  m_instr);
        chk("opcode", opcode, m_instr >> 12);
        chk("pc_out", pc_out, m_pc_out);
        chk("valid",  valid,  m_valid);
        chk("halted", halted, (m_state == S_HALT) ? 1 : 0);
    endtask

    task automatic quiet();
        start        = 1'b0;
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_we      = 1'b0;
    endtask

    task automatic load(input int addr, input logic [IW-1:0] data);
        imem_we    = 1'b1;
        imem_addr  = PC_W'(addr);
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 40 && !halted; i++) step();
        chk(tag, halted, 1);
    endtask

    initial begin
        logic [IW-1:0] prog [4];
        prog = '{16'h1000, 16'h2000, 16'h3000, 16'hF000};
        m_state = S_IDLE; m_pc = 0; m_instr = 0; m_pc_out = 0; m_valid = 0;
        foreach (m_mem[i]) m_mem[i] = 0;
        quiet();
        branch_target = '0;
        imem_addr     = '0;
        imem_wdata    = '0;
        rst           = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_instr", instr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_halted", halted, 0);

        // Load and run
        for (int i = 0; i < DEPTH; i++) load(i, (i < 4) ? prog[i] : 16'h1000);
        kick();
        step(); chk("run_op0", opcode, 1); chk("run_pc0", pc_out, 0); chk("run_v0", valid, 1);
        step(); chk("run_op1", opcode, 2); chk("run_pc1", pc_out, 1); chk("run_v1", valid, 1);
        step(); chk("run_op2", opcode, 3); chk("run_pc2", pc_out, 2); chk("run_v2", valid, 1);
        step(); chk("halt_valid", valid, 0); chk("halt_flag", halted, 1);

        // Stall while pc_out = 1
        kick();
        step(); step();
        chk("pre_stall_pc", pc_out, 1);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_instr", instr, 16'h2000);
            chk("stall_valid", valid, 1);
            chk("stall_pc", pc_out, 1);
        end
        stall = 1'b0;
        step(); chk("post_stall_pc", pc_out, 2);

        // Branch beats stall, and also beats the halt word at PC 3
        branch_taken = 1'b1; branch_target = 4'd0; stall = 1'b1;
        step(); chk("br_bubble", valid, 0); chk("br_nohalt", halted, 0);
        branch_taken = 1'b0; stall = 1'b0;
        step(); chk("br_pc", pc_out, 0); chk("br_op", opcode, 1); chk("br_valid", valid, 1);
        run_to_halt("br_halt");

        // Branch over halt without stall
        kick();
        step(); step(); step();
        branch_taken = 1'b1; branch_target = 4'd1;
        step(); chk("boh_halted", halted, 0); chk("boh_valid", valid, 0);
        branch_taken = 1'b0;
        step(); chk("boh_pc", pc_out, 1); chk("boh_op", opcode, 2);
        step(); chk("boh_pc2", pc_out, 2);
        run_to_halt("boh_halt");

        // Write to address 0 on the same edge as start
        start = 1'b1; imem_we = 1'b1; imem_addr = '0; imem_wdata = 16'h7000;
        step();
        quiet();
        step(); chk("coll_op", opcode, 7); chk("coll_pc", pc_out, 0); chk("coll_v", valid, 1);
        run_to_halt("coll_halt");

        // Wrap-around with no halt word
        for (int i = 0; i < DEPTH; i++) load(i, 16'h1000);
        kick();
        for (int i = 0; i < DEPTH; i++) step();
        chk("wrap_pc15", pc_out, 15); chk("wrap_v15", valid, 1);
        step(); chk("wrap_pc0", pc_out, 0); chk("wrap_v0", valid, 1);

        // Reset mid-run beats stall and branch
        rst = 1'b1; stall = 1'b1; branch_taken = 1'b1; branch_target = 4'd5;
        step();
        chk("mrst_instr", instr, 0); chk("mrst_pc", pc_out, 0);
        chk("mrst_valid", valid, 0); chk("mrst_halted", halted, 0);
        rst = 1'b0; quiet();
        for (int i = 0; i < 3; i++) step();
        chk("idle_valid", valid, 0);

        // Writes during RUN are dropped
        load(4, 16'hF000);
        kick();
        step(); step();
        imem_we = 1'b1; imem_addr = 4'd2; imem_wdata = 16'hF000;
        step();
        imem_we = 1'b0;
        run_to_halt("we_halt");
        chk("we_last_pc", pc_out, 3);
        kick();
        step(); step(); step();
        chk("we_rerun_pc", pc_out, 2); chk("we_rerun_op", opcode, 1); chk("we_rerun_v", valid, 1);
        run_to_halt("we_rerun_halt");

        // Randomized traffic against the model
        for (int i = 0; i < DEPTH; i++) load(i, IW'($urandom));
        for (int n = 0; n < 600; n++) begin
            rst           = ($urandom_range(0, 99) < 2);
            start         = ($urandom_range(0, 99) < 8);
            stall         = ($urandom_range(0, 99) < 25);
            branch_taken  = ($urandom_range(0, 99) < 15);
            branch_target = PC_W'($urandom);
            imem_we       = ($urandom_range(0, 99) < 20);
            imem_addr     = PC_W'($urandom);
            imem_wdata    = IW'($urandom);
            step();
        end
        rst = 1'b0;
        quiet();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that sits directly upstream of `control_unit`. It holds the program counter and a small writable instruction memory, and registers each fetched word in an IF/ID pipeline register. The registered `opcode` field drives `control_unit`. The block supports pipeline stall, branch redirect with flush, and a halt opcode, and it sequences IDLE/RUN/HALT through a small state machine.

## Interface
Parameters:
- `DEPTH`, 16: instruction memory words; power of two, ≥ 2.
- `IW`, 16: instruction width; opcode occupies `[IW-1:IW-4]`.
- `PC_W`, `$clog2(DEPTH)`: program counter width; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — system clock, rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `start`  in  1  — begin execution at PC 0; honoured in IDLE and HALT only.
- `stall`  in  1  — hold PC and the IF/ID register.
- `branch_taken`  in  1  — redirect from execute (`Branch` & condition).
- `branch_target`  in  `PC_W`  — redirect address.
- `imem_we`  in  1  — instruction memory write enable; honoured in IDLE and HALT only.
- `imem_addr`  in  `PC_W`  — write address.
- `imem_wdata`  in  `IW`  — write data.
- `instr`  out  `IW`  — IF/ID instruction.
- `opcode`  out  4  — `instr[IW-1:IW-4]`; feeds `control_unit`.
- `pc_out`  out  `PC_W`  — address of `instr`.
- `valid`  out  1  — `instr` is a real instruction; downstream treats `valid`=0 as a bubble.
- `halted`  out  1  — high in HALT state.

## Operation
- **Reset values:** state IDLE, PC=0, `instr`=0, `pc_out`=0, `valid`=0, `halted`=0. Memory contents are not cleared.
- **IDLE:**
  - `valid`=0.
  - `imem_we` writes `imem_wdata` to `imem[imem_addr]`.
  - `start` → RUN, with PC=0.
- **RUN, cycle priority (highest first):**
  1. `branch_taken`: PC←`branch_target`, `valid`←0 (flush), `instr` and `pc_out` unchanged. Branch overrides `stall`. It also overrides a halt word fetched that cycle, because that word is wrong-path.
  2. `stall`: PC, `instr`, `pc_out` and `valid` hold.
  3. Fetched word `imem[PC]` has opcode `OP_HALT` (4'hF): `valid`←0, PC holds, state→HALT. The halt word is never issued downstream.
  4. Otherwise: `instr`←`imem[PC]`, `pc_out`←PC, `valid`←1, PC←PC+1 modulo `DEPTH` (wraps `DEPTH-1`→0).
- **Writes in RUN:** `imem_we` is ignored.
- **HALT:**
  - `halted`=1 and `valid`=0.
  - `imem_we` is honoured.
  - `start` → RUN with PC=0 (`halted` drops the same edge).
  - `stall` and `branch_taken` are ignored.
- **Reset mid-RUN:** applies on the next edge regardless of stall or branch. The pipeline register is cleared and no partial instruction is issued.
- **Write/fetch collision** (same cycle, IDLE→RUN on `start` with `imem_we` to address 0): the write lands, and the first RUN fetch (next cycle) sees the new data.

## Timing
- Memory read is asynchronous; the IF/ID register makes fetch latency 1 cycle: PC=p at edge n gives `instr`=`imem[p]` after edge n+1.
- `start` sampled at edge n: RUN from n; first `valid`=1 after edge n+1.
- Branch penalty:
  - One bubble (`valid`=0) after the edge that samples `branch_taken`.
  - Target instruction valid one edge later.
- Stall has zero-cycle effect: outputs hold on the sampling edge.
- Throughput: one instruction per cycle when there is no stall or branch.

## Structure
- **Package `cpu_pkg`:**
  - `opcode_t` (4-bit).
  - `OP_HALT = 4'hF`.
  - Opcode field position constants.
  - `fetch_state_t` enum {IDLE, RUN, HALT}.
  - `control_unit` imports the same `opcode_t`.
- **Sub-module `imem`:** `DEPTH`×`IW` array with a synchronous write port and an asynchronous read port. `fetch_unit` holds the PC, the FSM and the IF/ID register.

## Test plan
- **Load and run:** load 0x1000, 0x2000, 0x3000, 0xF000 at addresses 0–3, then pulse `start`. Expect:
  - `opcode` 1, 2, 3 with `pc_out` 0, 1, 2 and `valid`=1 on consecutive cycles;
  - then `valid`=0, `halted`=1, PC held at 3.
- **Stall:** `stall` high 3 cycles while `pc_out`=1. Expect `instr`=0x2000 and `valid`=1 held for 3 cycles, then `pc_out`=2.
- **Branch with stall:** `branch_taken`=1, `target`=0, `stall`=1 in the same cycle. Expect one `valid`=0 bubble, then `pc_out`=0 and `opcode`=1 (branch beats stall).
- **Branch over halt:** `branch_taken` asserted in the cycle PC=3 (halt word). Expect no HALT, `halted`=0, and the target stream continues.
- **Wrap-around:** `DEPTH`=16 filled with 0x1000 except none halt. Expect `pc_out` 15 followed by 0 with `valid` continuous.
- **Reset and writes:**
  - `rst` mid-RUN: all outputs zero next edge, state IDLE.
  - `imem_we` during RUN: the write is ignored, verified by reload-free re-execution after halt/`start`.
